// File: rtl/axi4_pkg.sv
// Shared AXI4 response codes and slave FSM state encodings.
package axi4_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_ADDR_DATA, W_DRAIN, W_COMMIT, W_RESP} wstate_e;
  typedef enum logic {R_ADDR, R_DATA} rstate_e;
endpackage

// File: rtl/axi4_regbank.sv
// Register storage with byte-strobe merge, per-register write pulse and a combinational read port.
module axi4_regbank #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  localparam int NB      = DATA_W / 8,
  localparam int IW      = $clog2(NUM_REGS)
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               we,
  input  logic [IW-1:0]                      widx,
  input  logic [DATA_W-1:0]                  wdata,
  input  logic [NB-1:0]                      wstrb,
  input  logic [IW-1:0]                      ridx,
  output logic [DATA_W-1:0]                  rdata,
  output logic [NUM_REGS-1:0][DATA_W-1:0]    regs,
  output logic [NUM_REGS-1:0]                wstrobe
);
  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = regs[widx];
    for (int b = 0; b < NB; b++)
      if (wstrb[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      regs    <= '0;
      wstrobe <= '0;
    end else begin
      wstrobe <= we ? (NUM_REGS'(1) << widx) : '0;
      if (we) regs[widx] <= merged;
    end
  end

  assign rdata = regs[ridx];
endmodule

// File: rtl/axi4_noburst_slave.sv
// Single-beat AXI4 register slave: independent write and read FSMs over axi4_regbank.
module axi4_noburst_slave #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGS       = 16
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [AXI_ADDR_WIDTH-1:0]          AXI_AWADDR,
  input  logic                               AXI_AWVALID,
  output logic                               AXI_AWREADY,
  input  logic [3:0]                         AXI_AWID,
  input  logic [7:0]                         AXI_AWLEN,
  input  logic [2:0]                         AXI_AWSIZE,
  input  logic [AXI_DATA_WIDTH-1:0]          AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]        AXI_WSTRB,
  input  logic                               AXI_WLAST,
  input  logic                               AXI_WVALID,
  output logic                               AXI_WREADY,
  output logic [1:0]                         AXI_BRESP,
  output logic [3:0]                         AXI_BID,
  output logic                               AXI_BVALID,
  input  logic                               AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]          AXI_ARADDR,
  input  logic                               AXI_ARVALID,
  output logic                               AXI_ARREADY,
  input  logic [3:0]                         AXI_ARID,
  input  logic [7:0]                         AXI_ARLEN,
  input  logic [2:0]                         AXI_ARSIZE,
  output logic [AXI_DATA_WIDTH-1:0]          AXI_RDATA,
  output logic [1:0]                         AXI_RRESP,
  output logic [3:0]                         AXI_RID,
  output logic                               AXI_RLAST,
  output logic                               AXI_RVALID,
  input  logic                               AXI_RREADY,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] REGS,
  output logic [NUM_REGS-1:0]                REG_WSTROBE
);
  import axi4_pkg::*;

  localparam int NB      = AXI_DATA_WIDTH / 8;
  localparam int IDX_LSB = $clog2(NB);
  localparam int IW      = $clog2(NUM_REGS);

  wstate_e w_state, w_state_d;
  rstate_e r_state, r_state_d;
  logic                      aw_held, aw_held_d, w_held, w_held_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [3:0]                awid_d;
  logic [7:0]                awlen_q, awlen_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]             wstrb_q, wstrb_d;
  logic                      wlast_q, wlast_d;
  logic                      awready_d, wready_d, bvalid_d;
  logic [1:0]                bresp_d;
  logic                      reg_we;

  logic                      arready_d, rvalid_d, rlast_d;
  logic [1:0]                rresp_d;
  logic [3:0]                rid_d;
  logic [7:0]                rcnt, rcnt_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_d, rd_data;

  logic [AXI_ADDR_WIDTH-1:0] aw_word, ar_word;
  logic                      aw_in_range, ar_in_range;
  logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] regs;
  logic                      unused_size;

  assign aw_word     = awaddr_q >> IDX_LSB;
  assign ar_word     = AXI_ARADDR >> IDX_LSB;
  assign aw_in_range = aw_word < AXI_ADDR_WIDTH'(NUM_REGS);
  assign ar_in_range = ar_word < AXI_ADDR_WIDTH'(NUM_REGS);
  assign unused_size = ^{AXI_AWSIZE, AXI_ARSIZE};
  assign REGS        = regs;

  axi4_regbank #(.DATA_W(AXI_DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_regbank (
    .clk     (clk),
    .resetn  (resetn),
    .we      (reg_we),
    .widx    (aw_word[IW-1:0]),
    .wdata   (wdata_q),
    .wstrb   (wstrb_q),
    .ridx    (ar_word[IW-1:0]),
    .rdata   (rd_data),
    .regs    (regs),
    .wstrobe (REG_WSTROBE)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state <= W_ADDR_DATA;  aw_held <= 1'b0;  w_held <= 1'b0;
      awaddr_q <= '0;  AXI_BID <= '0;  awlen_q <= '0;
      wdata_q <= '0;  wstrb_q <= '0;  wlast_q <= 1'b0;
      AXI_AWREADY <= 1'b0;  AXI_WREADY <= 1'b0;
      AXI_BVALID <= 1'b0;  AXI_BRESP <= RESP_OKAY;
    end else begin
      w_state <= w_state_d;  aw_held <= aw_held_d;  w_held <= w_held_d;
      awaddr_q <= awaddr_d;  AXI_BID <= awid_d;  awlen_q <= awlen_d;
      wdata_q <= wdata_d;  wstrb_q <= wstrb_d;  wlast_q <= wlast_d;
      AXI_AWREADY <= awready_d;  AXI_WREADY <= wready_d;
      AXI_BVALID <= bvalid_d;  AXI_BRESP <= bresp_d;
    end
  end

  always_comb begin
    w_state_d = w_state;  aw_held_d = aw_held;  w_held_d = w_held;
    awaddr_d = awaddr_q;  awid_d = AXI_BID;  awlen_d = awlen_q;
    wdata_d = wdata_q;  wstrb_d = wstrb_q;  wlast_d = wlast_q;
    awready_d = AXI_AWREADY;  wready_d = AXI_WREADY;
    bvalid_d = AXI_BVALID;  bresp_d = AXI_BRESP;
    reg_we = 1'b0;
    unique case (w_state)
      W_ADDR_DATA: begin
        if (AXI_AWVALID && AXI_AWREADY) begin
          aw_held_d = 1'b1;  awaddr_d = AXI_AWADDR;  awid_d = AXI_AWID;  awlen_d = AXI_AWLEN;
        end
        if (AXI_WVALID && AXI_WREADY) begin
          w_held_d = 1'b1;  wdata_d = AXI_WDATA;  wstrb_d = AXI_WSTRB;  wlast_d = AXI_WLAST;
        end
        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
        if (aw_held_d && w_held_d) begin
          // A burst whose first beat wasn't last must have its remaining beats swallowed.
          if (awlen_d != 8'd0 && !wlast_d) begin
            w_state_d = W_DRAIN;
            wready_d  = 1'b1;
          end else begin
            w_state_d = W_COMMIT;
          end
        end
      end
      W_DRAIN: begin
        if (AXI_WVALID && AXI_WREADY && AXI_WLAST) begin
          wready_d  = 1'b0;
          w_state_d = W_COMMIT;
        end
      end
      W_COMMIT: begin
        // Draining only happens for AWLEN != 0, so that path always lands on SLVERR here.
        reg_we    = (awlen_q == 8'd0) && aw_in_range;
        bresp_d   = reg_we ? RESP_OKAY : RESP_SLVERR;
        bvalid_d  = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (AXI_BREADY) begin
          bvalid_d = 1'b0;  aw_held_d = 1'b0;  w_held_d = 1'b0;
          awready_d = 1'b1;  wready_d = 1'b1;
          w_state_d = W_ADDR_DATA;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= R_ADDR;  rcnt <= '0;
      AXI_ARREADY <= 1'b0;  AXI_RVALID <= 1'b0;  AXI_RLAST <= 1'b0;
      AXI_RRESP <= RESP_OKAY;  AXI_RDATA <= '0;  AXI_RID <= '0;
    end else begin
      r_state <= r_state_d;  rcnt <= rcnt_d;
      AXI_ARREADY <= arready_d;  AXI_RVALID <= rvalid_d;  AXI_RLAST <= rlast_d;
      AXI_RRESP <= rresp_d;  AXI_RDATA <= rdata_d;  AXI_RID <= rid_d;
    end
  end

  always_comb begin
    r_state_d = r_state;  rcnt_d = rcnt;
    arready_d = AXI_ARREADY;  rvalid_d = AXI_RVALID;  rlast_d = AXI_RLAST;
    rresp_d = AXI_RRESP;  rdata_d = AXI_RDATA;  rid_d = AXI_RID;
    unique case (r_state)
      R_ADDR: begin
        arready_d = 1'b1;
        if (AXI_ARVALID && AXI_ARREADY) begin
          arready_d = 1'b0;
          rid_d     = AXI_ARID;
          rcnt_d    = AXI_ARLEN;
          rdata_d   = ar_in_range ? rd_data : '0;
          rresp_d   = (AXI_ARLEN == 8'd0 && ar_in_range) ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          rlast_d   = (AXI_ARLEN == 8'd0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (AXI_RREADY) begin
          if (rcnt == 8'd0) begin
            rvalid_d = 1'b0;  rlast_d = 1'b0;  arready_d = 1'b1;
            r_state_d = R_ADDR;
          end else begin
            rcnt_d  = rcnt - 8'd1;
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
            rlast_d = (rcnt == 8'd1);
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_axi4_noburst_slave.sv
// Directed bench: table of single-beat transactions plus hand sequences for ordering, bursts, backpressure and reset.
module tb_axi4_noburst_slave;
  localparam logic [1:0] OK = 2'b00, SE = 2'b10;

  logic clk = 1'b0, resetn = 1'b0;
  logic [31:0] AXI_AWADDR = '0, AXI_WDATA = '0, AXI_ARADDR = '0;
  logic        AXI_AWVALID = 0, AXI_WLAST = 0, AXI_WVALID = 0, AXI_BREADY = 0, AXI_ARVALID = 0, AXI_RREADY = 0;
  logic [3:0]  AXI_AWID = '0, AXI_WSTRB = '0, AXI_ARID = '0;
  logic [7:0]  AXI_AWLEN = '0, AXI_ARLEN = '0;
  logic [2:0]  AXI_AWSIZE = '0, AXI_ARSIZE = '0;
  logic        AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_ARREADY, AXI_RLAST, AXI_RVALID;
  logic [1:0]  AXI_BRESP, AXI_RRESP;
  logic [3:0]  AXI_BID, AXI_RID;
  logic [31:0] AXI_RDATA;
  logic [511:0] REGS;
  logic [15:0] REG_WSTROBE;

  axi4_noburst_slave dut (
    .clk(clk), .resetn(resetn),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_AWID(AXI_AWID), .AXI_AWLEN(AXI_AWLEN), .AXI_AWSIZE(AXI_AWSIZE),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST),
    .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BID(AXI_BID), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_ARID(AXI_ARID), .AXI_ARLEN(AXI_ARLEN), .AXI_ARSIZE(AXI_ARSIZE),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RID(AXI_RID), .AXI_RLAST(AXI_RLAST),
    .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
    .REGS(REGS), .REG_WSTROBE(REG_WSTROBE)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] exp;
    logic [15:0] strobe;
  } vec_t;

  int nvec = 0, nmis = 0;
  logic [31:0] mdl [16];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic check_regs(input string nm);
    for (int k = 0; k < 16; k++) check($sformatf("%s_reg%0d", nm, k), REGS[k*32 +: 32], mdl[k]);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [3:0] id, input int len, input int aw_delay, input int b_delay,
                          input bit do_b, output logic [1:0] resp, output logic [3:0] bid,
                          output logic [15:0] strobe, output int lat);
    int n = 0, wb = 0, n_aw = 0;
    bit aw_pend = 1, aw_f, w_f;
    strobe = '0;
    @(negedge clk);
    AXI_AWADDR = addr; AXI_AWID = id; AXI_AWLEN = 8'(len); AXI_AWSIZE = 3'd2;
    AXI_WDATA = data; AXI_WSTRB = strb; AXI_WLAST = (len == 0); AXI_WVALID = 1;
    AXI_AWVALID = (aw_delay == 0);
    while ((aw_pend || wb <= len) && n < 100) begin
      aw_f = AXI_AWVALID && AXI_AWREADY;
      w_f  = AXI_WVALID && AXI_WREADY;
      if (aw_f) n_aw = n;
      @(negedge clk); n++;
      strobe |= REG_WSTROBE;
      if (aw_f) begin aw_pend = 0; AXI_AWVALID = 0; end
      else if (aw_pend && n >= aw_delay) AXI_AWVALID = 1;
      if (w_f) begin
        wb++;
        AXI_WLAST = (wb == len);
        if (wb > len) AXI_WVALID = 0;
      end
    end
    if (n >= 100) begin
      nvec++; nmis++;
      $display("FAIL w_accept: got %0d beats required %0d", wb, len + 1);
      AXI_AWVALID = 0; AXI_WVALID = 0;
    end
    while (!AXI_BVALID && n < 200) begin @(negedge clk); n++; strobe |= REG_WSTROBE; end
    check("b_valid_seen", AXI_BVALID, 1);
    lat = n - n_aw; resp = AXI_BRESP; bid = AXI_BID;
    for (int i = 0; i < b_delay; i++) begin
      @(negedge clk);
      strobe |= REG_WSTROBE;
      check("bp_awready", AXI_AWREADY, 0);
      check("bp_bvalid", AXI_BVALID, 1);
      check("bp_bresp", AXI_BRESP, resp);
    end
    if (do_b) begin
      AXI_BREADY = 1;
      @(negedge clk);
      strobe |= REG_WSTROBE;
      AXI_BREADY = 0;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                         input logic [31:0] exp0, input logic [1:0] resp0,
                         input int stall_beat, input int stall_n);
    int n = 0;
    logic [31:0] ed; logic [1:0] er;
    @(negedge clk);
    AXI_ARADDR = addr; AXI_ARLEN = 8'(len); AXI_ARID = id; AXI_ARSIZE = 3'd2; AXI_ARVALID = 1;
    while (!AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    AXI_ARVALID = 0;
    check("r_latency", AXI_RVALID, 1);
    for (int b = 0; b <= len; b++) begin
      n = 0;
      while (!AXI_RVALID && n < 50) begin @(negedge clk); n++; end
      ed = (b == 0) ? exp0 : 32'h0;
      er = (b == 0) ? resp0 : SE;
      check($sformatf("r%0d_data", b), AXI_RDATA, ed);
      check($sformatf("r%0d_resp", b), AXI_RRESP, er);
      check($sformatf("r%0d_last", b), AXI_RLAST, (b == len));
      check($sformatf("r%0d_id", b), AXI_RID, id);
      if (b == stall_beat)
        for (int i = 0; i < stall_n; i++) begin
          @(negedge clk);
          check("stall_valid", AXI_RVALID, 1);
          check("stall_data", AXI_RDATA, ed);
          check("stall_resp", AXI_RRESP, er);
          check("stall_last", AXI_RLAST, (b == len));
        end
      AXI_RREADY = 1;
      @(negedge clk);
      AXI_RREADY = 0;
    end
    check("r_done", AXI_RVALID, 0);
  endtask

  vec_t vecs[9];
  logic [1:0] resp; logic [3:0] bid; logic [15:0] strobe; int lat;

  initial begin
    vecs[0] = '{1, 32'h08, 32'hDEADBEEF, 4'hF, 4'h3, OK, 32'hDEADBEEF, 16'h0004};
    vecs[1] = '{0, 32'h08, 32'h0,        4'h0, 4'h1, OK, 32'hDEADBEEF, 16'h0000};
    vecs[2] = '{1, 32'h04, 32'h12345678, 4'hC, 4'h5, OK, 32'h12340000, 16'h0002};
    vecs[3] = '{0, 32'h04, 32'h0,        4'h0, 4'h2, OK, 32'h12340000, 16'h0000};
    vecs[4] = '{1, 32'h3C, 32'hA5A5A5A5, 4'h1, 4'h7, OK, 32'h000000A5, 16'h8000};
    vecs[5] = '{0, 32'h3F, 32'h0,        4'h0, 4'hE, OK, 32'h000000A5, 16'h0000};
    vecs[6] = '{1, 32'h40, 32'hFFFFFFFF, 4'hF, 4'h9, SE, 32'h0,        16'h0000};
    vecs[7] = '{0, 32'h40, 32'h0,        4'h0, 4'h8, SE, 32'h0,        16'h0000};
    vecs[8] = '{0, 32'h00, 32'h0,        4'h0, 4'h0, OK, 32'h0,        16'h0000};
    for (int k = 0; k < 16; k++) mdl[k] = '0;

    // Reset values, then READYs rise on the first edge after release.
    repeat (3) @(negedge clk);
    check("rst_awready", AXI_AWREADY, 0);
    check("rst_wready", AXI_WREADY, 0);
    check("rst_arready", AXI_ARREADY, 0);
    check("rst_valids", {AXI_BVALID, AXI_RVALID, AXI_RLAST}, 0);
    check("rst_payload", {AXI_BRESP, AXI_RRESP, AXI_BID, AXI_RID, AXI_RDATA}, 0);
    check("rst_wstrobe", REG_WSTROBE, 0);
    check_regs("rst");
    resetn = 1;
    @(negedge clk);
    check("post_rst_readies", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 3'b111);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].id, 0, 0, 0, 1, resp, bid, strobe, lat);
        check($sformatf("v%0d_bresp", i), resp, vecs[i].resp);
        check($sformatf("v%0d_bid", i), bid, vecs[i].id);
        check($sformatf("v%0d_strobe", i), strobe, vecs[i].strobe);
        check($sformatf("v%0d_lat", i), lat, 2);
        if (vecs[i].strobe != 0) mdl[vecs[i].addr[5:2]] = vecs[i].exp;
        check_regs($sformatf("v%0d", i));
      end else begin
        do_read(vecs[i].addr, 0, vecs[i].id, vecs[i].exp, vecs[i].resp, -1, 0);
      end
    end

    // Narrow write with W presented three cycles ahead of AW.
    do_write(32'h08, 32'h0000AB00, 4'h2, 4'h4, 0, 3, 0, 1, resp, bid, strobe, lat);
    check("narrow_bresp", resp, OK);
    check("narrow_lat", lat, 2);
    check("narrow_strobe", strobe, 16'h0004);
    mdl[2] = 32'hDEADABEF;
    check_regs("narrow");
    do_read(32'h08, 0, 4'h4, 32'hDEADABEF, OK, -1, 0);

    // Four-beat write burst: drained, one SLVERR response, nothing written.
    do_write(32'h00, 32'h55555555, 4'hF, 4'hA, 3, 0, 0, 1, resp, bid, strobe, lat);
    check("wburst_bresp", resp, SE);
    check("wburst_bid", bid, 4'hA);
    check("wburst_strobe", strobe, 0);
    check_regs("wburst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wburst_single_b", AXI_BVALID, 0);
    end

    // Three-beat read burst with RREADY held off on the second beat.
    do_read(32'h80, 2, 4'h6, 32'h0, SE, 1, 5);

    // B backpressure keeps AWREADY low until the handshake.
    do_write(32'h10, 32'hCAFEF00D, 4'hF, 4'h2, 0, 0, 10, 1, resp, bid, strobe, lat);
    check("bp_resp", resp, OK);
    check("bp_strobe", strobe, 16'h0010);
    check("bp_awready_after", AXI_AWREADY, 1);
    mdl[4] = 32'hCAFEF00D;
    check_regs("bp");

    // Reset while BVALID is pending drops the response and clears the registers.
    do_write(32'h14, 32'h11111111, 4'hF, 4'h1, 0, 0, 0, 0, resp, bid, strobe, lat);
    check("mr_bvalid_pre", AXI_BVALID, 1);
    resetn = 0;
    @(negedge clk);
    check("mr_bvalid", AXI_BVALID, 0);
    check("mr_awready", AXI_AWREADY, 0);
    for (int k = 0; k < 16; k++) mdl[k] = '0;
    check_regs("mr");
    resetn = 1;
    @(negedge clk);
    check("mr_readies", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID}, 4'b1110);
    do_read(32'h14, 0, 4'h3, 32'h0, OK, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/axi4_noburst_slave.md
# axi4_noburst_slave

AXI4 slave endpoint exposing a bank of `NUM_REGS` data-width registers to an AXI4 master, typically the team's single-beat master. It accepts single-beat reads and writes, honours `WSTRB` for narrow writes, and drives the register contents out to fabric logic. Bursts and out-of-range addresses are fully consumed on the bus and answered with SLVERR.

## Interface
- `AXI_DATA_WIDTH`, default 32: data bus width in bits, a power of 2 and at least 32.
- `AXI_ADDR_WIDTH`, default 32: address bus width in bits.
- `NUM_REGS`, default 16: number of registers, a power of 2 and at least 2.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `AXI_AWADDR` in ADDR, `AXI_AWVALID` in 1, `AXI_AWREADY` out 1: write address channel.
- `AXI_AWID` in 4, `AXI_AWLEN` in 8, `AXI_AWSIZE` in 3: write ID, burst length and beat size; `AWSIZE` is ignored.
- `AXI_WDATA` in DATA, `AXI_WSTRB` in DATA/8, `AXI_WLAST` in 1, `AXI_WVALID` in 1, `AXI_WREADY` out 1: write data channel.
- `AXI_BRESP` out 2, `AXI_BID` out 4, `AXI_BVALID` out 1, `AXI_BREADY` in 1: write response channel.
- `AXI_ARADDR` in ADDR, `AXI_ARVALID` in 1, `AXI_ARREADY` out 1, `AXI_ARID` in 4, `AXI_ARLEN` in 8, `AXI_ARSIZE` in 3: read address channel; `ARSIZE` is ignored.
- `AXI_RDATA` out DATA, `AXI_RRESP` out 2, `AXI_RID` out 4, `AXI_RLAST` out 1, `AXI_RVALID` out 1, `AXI_RREADY` in 1: read data channel.
- `REGS` out NUM_REGS*DATA: flattened register contents; register k occupies bits [k*DATA +: DATA].
- `REG_WSTROBE` out NUM_REGS: bit k pulses high for one cycle when register k is written.

## Operation
- Register index = `ADDR >> log2(DATA/8)`. The index is in range when it is less than `NUM_REGS`. Low address bits are ignored; lane selection comes only from `WSTRB`.
- **Write FSM, state W_ADDR_DATA**: `AWREADY` and `WREADY` are both high.
  - The AW and W handshakes are captured independently, in either order or together.
  - Each channel's READY drops after its own handshake.
  - Once both channels are held, go to W_COMMIT.
- **W_COMMIT** (one cycle):
  - If `AWLEN == 0` and the index is in range: update every byte lane whose `WSTRB` bit is set, pulse `REG_WSTROBE[idx]`, set BRESP = OKAY.
  - Otherwise set BRESP = SLVERR and write nothing.
  - Go to W_RESP.
- **W_DRAIN**: entered instead of W_COMMIT when the captured `AWLEN != 0` and the captured W beat had `WLAST = 0`.
  - `WREADY` is high; W beats are accepted and discarded.
  - On a beat with `WLAST = 1`, go to W_COMMIT with SLVERR forced.
- **W_RESP**: `BVALID` is high and `BID` is the captured `AWID`. On the B handshake, go to W_ADDR_DATA with both READYs high.
- **Read FSM, state R_ADDR**: `ARREADY` is high.
  - On the AR handshake, latch the ID and `ARLEN`, and load the beat counter with `ARLEN`.
  - Sample RDATA: the register value if the index is in range, otherwise 0.
  - Set RRESP = OKAY only if `ARLEN == 0` and the index is in range, otherwise SLVERR.
  - Go to R_DATA.
- **R_DATA**: `RVALID` is high; `RLAST` is high when the beat counter is 0.
  - On an R handshake with counter 0, go to R_ADDR.
  - On an R handshake with counter above 0, decrement the counter and keep SLVERR with RDATA = 0.
- The read and write FSMs are fully independent and run concurrently.

## Timing
- **Reset values**:
  - All READY, VALID, `RLAST` and `REG_WSTROBE` outputs: 0.
  - BRESP, RRESP, RDATA, BID, RID: 0.
  - All registers: 0.
- `AWREADY`, `WREADY` and `ARREADY` go high on the first edge after `resetn` deasserts.
- **Write latency**: with the final AW/W handshake in cycle N, registers, `REG_WSTROBE` and BRESP update at the end of cycle N+1, and `BVALID` is high from cycle N+2.
- **Read latency**: with the AR handshake in cycle N, `RVALID` is high from cycle N+1.
  - RDATA reflects the register state during cycle N.
  - A write committing at the end of cycle N is not visible in that read.
- Once asserted, `BVALID` and `RVALID` stay high with stable payload until their handshake.
- Reset asserted mid-transaction aborts all state immediately and applies the reset values. A pending response is dropped.

## Structure
- Shared package `axi4_pkg`:
  - Response constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - Write FSM state encodings: W_ADDR_DATA, W_DRAIN, W_COMMIT, W_RESP.
  - Read FSM state encodings: R_ADDR, R_DATA.
- Sub-module `axi4_regbank`:
  - Holds register storage, byte-strobe merge and `REG_WSTROBE` generation.
  - Write port: index, data, strobe, enable. Read port: combinational read by index.
  - The top level contains only the two FSMs.

## Test plan
- **Full-width write then read**: AW and W together, addr 0x8, data 0xDEADBEEF, WSTRB 0xF → BRESP OKAY and `REG_WSTROBE[2]` pulses. Then AR addr 0x8 → RDATA 0xDEADBEEF, RRESP OKAY, `RLAST` = 1.
- **Narrow write and W before AW**: W data 0x0000AB00 with WSTRB 0x2 presented 3 cycles before AW addr 0x8 → register 2 reads 0xDEADABEF, and BVALID appears 2 cycles after the AW handshake.
- **Out-of-range write**: addr 0x40 with NUM_REGS=16 → BRESP SLVERR, no `REG_WSTROBE` pulse, all registers unchanged.
- **Write burst**: AWLEN=3 with 4 W beats, the last carrying `WLAST` → all beats accepted, exactly one B with SLVERR, and BID equal to AWID.
- **Read burst**: ARLEN=2 → 3 R beats, each SLVERR with RDATA 0, `RLAST` only on beat 3. Hold `RREADY` low 5 cycles on beat 2 → payload remains stable throughout.
- **Reset mid-transaction and backpressure**: assert reset while `BVALID` is high → `BVALID` is 0 on the next cycle and registers read back 0. Hold `BREADY` low 10 cycles → `AWREADY` stays low until the B handshake completes.
